// File: rtl/brick_grid_scanner.sv
`default_nettype none
// ============================================================================
// Module      : brick_grid_scanner
// Description : Walks the level memory one cell per clock and reports the
//               first brick overlapping the ball box (cell, type and side),
//               plus a saturating count of all overlapping bricks.
//               Optional macro EARLY_EXIT_EN ends the scan at the first hit.
// Revision    : 1.0 - initial release
// ============================================================================
module brick_grid_scanner #(
    parameter int GRID_COLS = 10,
    parameter int GRID_ROWS = 8,
    parameter int BRICK_W   = 12,
    parameter int BRICK_H   = 6,
    parameter int BALL_W    = 6,
    parameter int BALL_H    = 6,
    parameter int ORIGIN_X  = 20,
    parameter int ORIGIN_Y  = 20,
    parameter int COORD_W   = 8,
    parameter int TYPE_W    = 4,
    parameter int MARGIN    = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [COORD_W-1:0]           ball_x,
    input  logic [COORD_W-1:0]           ball_y,
    output logic [$clog2(GRID_COLS)-1:0] rd_col,
    output logic [$clog2(GRID_ROWS)-1:0] rd_row,
    input  logic [TYPE_W-1:0]            rd_type,
    output logic                         busy,
    output logic                         done,
    output logic                         hit,
    output logic [$clog2(GRID_COLS)-1:0] hit_col,
    output logic [$clog2(GRID_ROWS)-1:0] hit_row,
    output logic [TYPE_W-1:0]            hit_type,
    output logic [2:0]                   hit_dir,
    output logic [7:0]                   hit_count
);
    localparam int CW = $clog2(GRID_COLS);
    localparam int RW = $clog2(GRID_ROWS);
    localparam int SW = COORD_W + 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state, w_next;
    logic [CW-1:0]       r_col, r_ecol;
    logic [RW-1:0]       r_row, r_erow;
    logic                r_evalid;
    logic [COORD_W-1:0]  r_ball_x, r_ball_y;
    logic                r_hit;
    logic [CW-1:0]       r_hit_col;
    logic [RW-1:0]       r_hit_row;
    logic [TYPE_W-1:0]   r_hit_type;
    logic [2:0]          r_hit_dir;
    logic [7:0]          r_hit_count;

    logic                w_last, w_eval, w_collide;
    logic [2:0]          w_dir;
    logic signed [SW-1:0] w_px, w_py, w_bx, w_by;
    logic signed [SW-1:0] w_bx_lo, w_bx_hi, w_by_lo, w_by_hi;

    assign w_last = (r_col == CW'(GRID_COLS - 1)) && (r_row == RW'(GRID_ROWS - 1));

    // Once a hit is recorded in early-exit mode, trailing reads are discarded.
`ifdef EARLY_EXIT_EN
    assign w_eval = r_evalid && !r_hit;
`else
    assign w_eval = r_evalid;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_SCAN;
            S_SCAN:  if (w_last) w_next = S_FLUSH;
            S_FLUSH: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
`ifdef EARLY_EXIT_EN
        if ((r_state == S_SCAN || r_state == S_FLUSH) && r_hit)
            w_next = S_DONE;
`endif
    end

    // Widened signed geometry so box edges left of/above zero compare correctly.
    always_comb begin
        w_px    = $signed({2'b00, r_ball_x});
        w_py    = $signed({2'b00, r_ball_y});
        w_bx    = SW'(ORIGIN_X + int'(r_ecol) * BRICK_W);
        w_by    = SW'(ORIGIN_Y + int'(r_erow) * BRICK_H);
        w_bx_lo = w_bx - SW'(BALL_W);
        w_bx_hi = w_bx + SW'(BRICK_W);
        w_by_lo = w_by - SW'(BALL_H);
        w_by_hi = w_by + SW'(BRICK_H);
        w_collide = (rd_type != '0) && (w_px > w_bx_lo) && (w_px < w_bx_hi)
                 && (w_py > w_by_lo) && (w_py < w_by_hi);
        w_dir = 3'd4;
        if (w_py <= w_by_lo + SW'(MARGIN))      w_dir = 3'd2;
        else if (w_py >= w_by_hi - SW'(MARGIN)) w_dir = 3'd3;
        else if (w_px <= w_bx_lo + SW'(MARGIN)) w_dir = 3'd0;
        else if (w_px >= w_bx_hi - SW'(MARGIN)) w_dir = 3'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_col       <= '0;
            r_row       <= '0;
            r_ecol      <= '0;
            r_erow      <= '0;
            r_evalid    <= 1'b0;
            r_ball_x    <= '0;
            r_ball_y    <= '0;
            r_hit       <= 1'b0;
            r_hit_col   <= '0;
            r_hit_row   <= '0;
            r_hit_type  <= '0;
            r_hit_dir   <= 3'd4;
            r_hit_count <= '0;
        end else begin
            r_ecol   <= r_col;
            r_erow   <= r_row;
            r_evalid <= (r_state == S_SCAN);

            if (w_eval && w_collide) begin
                if (!r_hit) begin
                    r_hit      <= 1'b1;
                    r_hit_col  <= r_ecol;
                    r_hit_row  <= r_erow;
                    r_hit_type <= rd_type;
                    r_hit_dir  <= w_dir;
                end
                if (r_hit_count != 8'hFF) r_hit_count <= r_hit_count + 8'd1;
            end

            if (r_state == S_IDLE && start) begin
                r_ball_x    <= ball_x;
                r_ball_y    <= ball_y;
                r_col       <= '0;
                r_row       <= '0;
                r_hit       <= 1'b0;
                r_hit_col   <= '0;
                r_hit_row   <= '0;
                r_hit_type  <= '0;
                r_hit_dir   <= 3'd4;
                r_hit_count <= '0;
            end else if (r_state == S_SCAN) begin
                if (r_col == CW'(GRID_COLS - 1)) begin
                    r_col <= '0;
                    r_row <= (r_row == RW'(GRID_ROWS - 1)) ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
        end
    end

    assign rd_col    = r_col;
    assign rd_row    = r_row;
    assign busy      = (r_state == S_SCAN) || (r_state == S_FLUSH);
    assign done      = (r_state == S_DONE);
    assign hit       = r_hit;
    assign hit_col   = r_hit_col;
    assign hit_row   = r_hit_row;
    assign hit_type  = r_hit_type;
    assign hit_dir   = r_hit_dir;
    assign hit_count = r_hit_count;

endmodule
`default_nettype wire

// File: tb/tb_brick_grid_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_brick_grid_scanner
// Description : Directed bench for brick_grid_scanner with a registered
//               level-memory model (default geometry, 10x8 grid).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_brick_grid_scanner;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] ball_x = '0, ball_y = '0;
    logic [3:0] rd_col;
    logic [2:0] rd_row;
    logic [3:0] rd_type = '0;
    logic       busy, done, hit;
    logic [3:0] hit_col;
    logic [2:0] hit_row;
    logic [3:0] hit_type;
    logic [2:0] hit_dir;
    logic [7:0] hit_count;

    logic [3:0] mem [0:79];
    int total = 0;
    int bad = 0;

    brick_grid_scanner dut (
        .clk(clk), .reset(reset), .start(start), .ball_x(ball_x), .ball_y(ball_y),
        .rd_col(rd_col), .rd_row(rd_row), .rd_type(rd_type), .busy(busy), .done(done),
        .hit(hit), .hit_col(hit_col), .hit_row(hit_row), .hit_type(hit_type),
        .hit_dir(hit_dir), .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    // One-cycle-latency level memory.
    always @(posedge clk) begin
        int idx;
        idx = int'(rd_row) * 10 + int'(rd_col);
        rd_type <= (idx < 80) ? mem[idx] : 4'd0;
    end

    task automatic fill_mem(input logic [3:0] v);
        for (int i = 0; i < 80; i++) mem[i] = v;
    endtask

    // Done cycle for a scan whose first hit is cell index k (-1 = no hit).
    function automatic int exp_done_for(input int k);
`ifdef EARLY_EXIT_EN
        if (k >= 0) return (k + 4 < 82) ? k + 4 : 82;
`endif
        return 82;
    endfunction

    task automatic run_scan(input int exp_done, input int restart_at,
                            output int done_cyc, output int busy_err, output int pulses);
        done_cyc = -1; busy_err = 0; pulses = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == restart_at) begin start = 1'b1; ball_x = 8'd125; ball_y = 8'd60; end
            if (c == restart_at + 1) start = 1'b0;
            if (busy !== (c < exp_done)) busy_err++;
            if (done === 1'b1) begin
                pulses++;
                if (done_cyc < 0) done_cyc = c;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0d exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0d exp=0", done); end
        total++; if (hit !== 1'b0) begin bad++; $display("FAIL rst_hit got=%0d exp=0", hit); end
        total++; if (hit_dir !== 3'd4) begin bad++; $display("FAIL rst_dir got=%0d exp=4", hit_dir); end
        total++; if (hit_count !== 8'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", hit_count); end
        total++; if ({rd_col, rd_row} !== 7'd0) begin bad++; $display("FAIL rst_addr got=%0d/%0d exp=0/0", rd_col, rd_row); end
    endtask

    task automatic test_empty;
        int dc, be, pu;
        fill_mem(4'd0); ball_x = 8'd18; ball_y = 8'd16;
        run_scan(82, 0, dc, be, pu);
        total++; if (dc != 82) begin bad++; $display("FAIL empty_done got=%0d exp=82", dc); end
        total++; if (be != 0) begin bad++; $display("FAIL empty_busy got=%0d bad cycles exp=0", be); end
        total++; if (pu != 1) begin bad++; $display("FAIL empty_pulses got=%0d exp=1", pu); end
        total++; if ({hit, hit_dir, hit_count} !== {1'b0, 3'd4, 8'd0})
            begin bad++; $display("FAIL empty_result got=%0d/%0d/%0d exp=0/4/0", hit, hit_dir, hit_count); end
    endtask

    task automatic check_hit(input string nm, input int k, input logic [3:0] col, input logic [2:0] row,
                             input logic [3:0] typ, input logic [2:0] dir, input logic [7:0] cnt);
        int dc, be, pu;
        run_scan(exp_done_for(k), 0, dc, be, pu);
        total++; if (dc != exp_done_for(k)) begin bad++; $display("FAIL %s_done got=%0d exp=%0d", nm, dc, exp_done_for(k)); end
        total++; if (be != 0) begin bad++; $display("FAIL %s_busy got=%0d bad cycles exp=0", nm, be); end
        total++; if (hit !== 1'b1) begin bad++; $display("FAIL %s_hit got=%0d exp=1", nm, hit); end
        total++; if ({hit_col, hit_row} !== {col, row}) begin bad++; $display("FAIL %s_cell got=%0d,%0d exp=%0d,%0d", nm, hit_col, hit_row, col, row); end
        total++; if (hit_type !== typ) begin bad++; $display("FAIL %s_type got=%0d exp=%0d", nm, hit_type, typ); end
        total++; if (hit_dir !== dir) begin bad++; $display("FAIL %s_dir got=%0d exp=%0d", nm, hit_dir, dir); end
        total++; if (hit_count !== cnt) begin bad++; $display("FAIL %s_count got=%0d exp=%0d", nm, hit_count, cnt); end
    endtask

    task automatic test_sides;
        fill_mem(4'd0); mem[0] = 4'd1; ball_x = 8'd18; ball_y = 8'd16;
        check_hit("top", 0, 4'd0, 3'd0, 4'd1, 3'd2, 8'd1);
        fill_mem(4'd0); mem[23] = 4'd2; ball_x = 8'd66; ball_y = 8'd34;
        check_hit("right", 23, 4'd3, 3'd2, 4'd2, 3'd1, 8'd1);
        fill_mem(4'd0); mem[2] = 4'd4; ball_x = 8'd39; ball_y = 8'd23;
        check_hit("left", 2, 4'd2, 3'd0, 4'd4, 3'd0, 8'd1);
        fill_mem(4'd0); mem[31] = 4'd6; ball_x = 8'd36; ball_y = 8'd42;
        check_hit("bottom", 31, 4'd1, 3'd3, 4'd6, 3'd3, 8'd1);
    endtask

    task automatic test_interior_pair;
        fill_mem(4'd0); mem[14] = 4'd5; mem[15] = 4'd7; ball_x = 8'd76; ball_y = 8'd29;
`ifdef EARLY_EXIT_EN
        check_hit("pair", 14, 4'd4, 3'd1, 4'd5, 3'd4, 8'd1);
`else
        check_hit("pair", 14, 4'd4, 3'd1, 4'd5, 3'd4, 8'd2);
`endif
    endtask

    task automatic test_back_to_back;
        int dc, be, pu;
        fill_mem(4'd3); ball_x = 8'd0; ball_y = 8'd0;
        run_scan(82, 10, dc, be, pu);
        total++; if (pu != 1) begin bad++; $display("FAIL b2b_pulses got=%0d exp=1", pu); end
        total++; if (dc != 82) begin bad++; $display("FAIL b2b_done got=%0d exp=82", dc); end
        total++; if (be != 0) begin bad++; $display("FAIL b2b_busy got=%0d bad cycles exp=0", be); end
        total++; if ({hit, hit_dir, hit_count} !== {1'b0, 3'd4, 8'd0})
            begin bad++; $display("FAIL b2b_result got=%0d/%0d/%0d exp=0/4/0", hit, hit_dir, hit_count); end
    endtask

    task automatic test_reset_mid_scan;
        int pu;
        fill_mem(4'd0); mem[79] = 4'd9; ball_x = 8'd125; ball_y = 8'd60;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 40) reset = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        total++; if ({busy, done, hit, hit_dir, hit_count} !== {1'b0, 1'b0, 1'b0, 3'd4, 8'd0})
            begin bad++; $display("FAIL mid_rst_out got=%0d/%0d/%0d/%0d/%0d exp=0/0/0/4/0", busy, done, hit, hit_dir, hit_count); end
        total++; if ({rd_col, rd_row} !== 7'd0) begin bad++; $display("FAIL mid_rst_addr got=%0d/%0d exp=0/0", rd_col, rd_row); end
        pu = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) pu++;
        end
        total++; if (pu != 0) begin bad++; $display("FAIL mid_rst_quiet got=%0d active cycles exp=0", pu); end
        check_hit("after_rst", 79, 4'd9, 3'd7, 4'd9, 3'd4, 8'd1);
    endtask

    initial begin
        fill_mem(4'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        test_reset;
        test_empty;
        test_sides;
        test_interior_pair;
        test_back_to_back;
        test_reset_mid_scan;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
